// File: rtl/dla_pkg.sv
// Shared types and constants for the DLA post-processing unit.
// Holds the PPU state encoding, channel limit and requantization bounds.
package dla_pkg;

    localparam int MAX_CH     = 32;

    localparam int Q_RELU_MIN = 0;
    localparam int Q_RELU_MAX = 255;
    localparam int Q_SGN_MIN  = -128;
    localparam int Q_SGN_MAX  = 127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS_REQ,
        ST_BIAS_CAP,
        ST_PS_REQ,
        ST_PS_CAP,
        ST_WRITE,
        ST_DONE
    } ppu_state_t;

    // Byte-enable covering lanes 0..last_lane of a packed output word.
    function automatic logic [3:0] tail_mask(input logic [1:0] last_lane);
        return 4'b1111 >> (2'd3 - last_lane);
    endfunction

endpackage

// File: rtl/ppu_quant.sv
// Combinational requantizer: bias add, optional ReLU, rounded shift, clamp.
// Internal math is two bits wider than the inputs so nothing can wrap.
module ppu_quant
    import dla_pkg::*;
#(
    parameter int W  = 32,
    parameter int OW = 8
) (
    input  logic [W-1:0]  psum,
    input  logic [W-1:0]  bias,
    input  logic [4:0]    shift,
    input  logic          relu_en,
    output logic [OW-1:0] q
);

    localparam int SW = W + 2;

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] pos;
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] shf;
    logic signed [SW-1:0] lo;
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] sat;

    // Add, rectify, round-half-up shift, then saturate to the output range.
    always_comb begin
        sum = SW'($signed(psum)) + SW'($signed(bias));
        pos = (relu_en && sum[SW-1]) ? '0 : sum;
        rnd = '0;
        if (shift != 5'd0) begin
            rnd[shift - 5'd1] = 1'b1;
        end
        shf = (pos + rnd) >>> shift;
        lo  = relu_en ? SW'(Q_RELU_MIN) : SW'(Q_SGN_MIN);
        hi  = relu_en ? SW'(Q_RELU_MAX) : SW'(Q_SGN_MAX);
        if (shf < lo) begin
            sat = lo;
        end else if (shf > hi) begin
            sat = hi;
        end else begin
            sat = shf;
        end
        q = OW'(sat);
    end

endmodule

// File: rtl/opsum_ppu.sv
// Output post-processing unit: loads per-channel bias, requantizes partial
// sums read from the GLB and writes packed output bytes back to the GLB.
module opsum_ppu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CH     = dla_pkg::MAX_CH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic [15:0]             num_pix,
    input  logic [5:0]              num_ch,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    input  logic [ADDR_WIDTH-1:0]   opsum_base,
    input  logic [ADDR_WIDTH-1:0]   bias_base,
    input  logic [ADDR_WIDTH-1:0]   out_base,
    output logic [3:0]              glb_re,
    output logic [ADDR_WIDTH-1:0]   glb_r_addr,
    input  logic [DATA_WIDTH*4-1:0] glb_r_data,
    output logic [3:0]              glb_we,
    output logic [ADDR_WIDTH-1:0]   glb_w_addr,
    output logic [DATA_WIDTH*4-1:0] glb_w_data
);

    import dla_pkg::*;

    localparam int BW = DATA_WIDTH * 4;
    localparam int CW = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
    localparam logic [ADDR_WIDTH-1:0] WSTEP = ADDR_WIDTH'(4);

    ppu_state_t state;

    logic [15:0]           np_q;
    logic [5:0]            nc_q;
    logic [4:0]            sh_q;
    logic                  relu_q;
    logic [ADDR_WIDTH-1:0] ops_q;
    logic [ADDR_WIDTH-1:0] wr_addr;

    logic [5:0]            ch;
    logic [15:0]           pix;
    logic [1:0]            lane;
    logic                  last_q;

    logic [BW-1:0]                    bias_file [MAX_CH];
    logic [3:0][DATA_WIDTH-1:0]       pbuf;
    logic [3:0][DATA_WIDTH-1:0]       word_nxt;
    logic [DATA_WIDTH-1:0]            qbyte;
    logic                             ch_last;
    logic                             pix_last;

    assign ch_last  = (ch == nc_q - 6'd1);
    assign pix_last = (pix == np_q - 16'd1);

    ppu_quant #(
        .W  (BW),
        .OW (DATA_WIDTH)
    ) u_quant (
        .psum    (glb_r_data),
        .bias    (bias_file[CW'(ch)]),
        .shift   (sh_q),
        .relu_en (relu_q),
        .q       (qbyte)
    );

    // Current pack buffer with the freshly computed byte dropped into its lane.
    always_comb begin
        word_nxt       = pbuf;
        word_nxt[lane] = qbyte;
    end

    // Main sequencer; every GLB strobe and status flag is a registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            glb_re     <= 4'b0000;
            glb_r_addr <= '0;
            glb_we     <= 4'b0000;
            glb_w_addr <= '0;
            glb_w_data <= '0;
            np_q       <= '0;
            nc_q       <= '0;
            sh_q       <= '0;
            relu_q     <= 1'b0;
            ops_q      <= '0;
            wr_addr    <= '0;
            ch         <= '0;
            pix        <= '0;
            lane       <= '0;
            last_q     <= 1'b0;
            pbuf       <= '0;
            for (int i = 0; i < MAX_CH; i++) begin
                bias_file[i] <= '0;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        np_q    <= num_pix;
                        nc_q    <= num_ch;
                        sh_q    <= shift;
                        relu_q  <= relu_en;
                        ops_q   <= opsum_base;
                        wr_addr <= out_base;
                        ch      <= '0;
                        pix     <= '0;
                        lane    <= '0;
                        last_q  <= 1'b0;
                        pbuf    <= '0;
                        if (num_pix == 16'd0 || num_ch == 6'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_BIAS_REQ;
                            busy       <= 1'b1;
                            glb_re     <= 4'b1111;
                            glb_r_addr <= bias_base;
                        end
                    end
                end
                ST_BIAS_REQ: begin
                    glb_re <= 4'b0000;
                    state  <= ST_BIAS_CAP;
                end
                ST_BIAS_CAP: begin
                    bias_file[CW'(ch)] <= glb_r_data;
                    glb_re             <= 4'b1111;
                    if (ch_last) begin
                        ch         <= '0;
                        glb_r_addr <= ops_q;
                        state      <= ST_PS_REQ;
                    end else begin
                        ch         <= ch + 6'd1;
                        glb_r_addr <= glb_r_addr + WSTEP;
                        state      <= ST_BIAS_REQ;
                    end
                end
                ST_PS_REQ: begin
                    glb_re <= 4'b0000;
                    state  <= ST_PS_CAP;
                end
                ST_PS_CAP: begin
                    if (ch_last) begin
                        ch  <= '0;
                        pix <= pix + 16'd1;
                    end else begin
                        ch <= ch + 6'd1;
                    end
                    if (lane == 2'd3 || (ch_last && pix_last)) begin
                        glb_we     <= tail_mask(lane);
                        glb_w_addr <= wr_addr;
                        glb_w_data <= word_nxt;
                        wr_addr    <= wr_addr + WSTEP;
                        pbuf       <= '0;
                        lane       <= '0;
                        last_q     <= ch_last && pix_last;
                        state      <= ST_WRITE;
                    end else begin
                        pbuf[lane] <= qbyte;
                        lane       <= lane + 2'd1;
                        glb_re     <= 4'b1111;
                        glb_r_addr <= glb_r_addr + WSTEP;
                        state      <= ST_PS_REQ;
                    end
                end
                ST_WRITE: begin
                    glb_we <= 4'b0000;
                    if (last_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        glb_re     <= 4'b1111;
                        glb_r_addr <= glb_r_addr + WSTEP;
                        state      <= ST_PS_REQ;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opsum_ppu.sv
// Bench for opsum_ppu: GLB model, fixed vectors, corner sequences and
// randomized runs checked against an arithmetic reference model.
module tb_opsum_ppu;

    localparam logic [31:0] BIAS_B = 32'h0000_0100;
    localparam logic [31:0] OPS_B  = 32'h0000_0400;
    localparam logic [31:0] OUT_B  = 32'h0001_0000;
    localparam int BIAS_W = 32'h100 / 4;
    localparam int OPS_W  = 32'h400 / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        relu_en = 1'b0;
    logic [15:0] num_pix = '0;
    logic [5:0]  num_ch = '0;
    logic [4:0]  shift = '0;
    logic [31:0] opsum_base = OPS_B;
    logic [31:0] bias_base = BIAS_B;
    logic [31:0] out_base = OUT_B;
    logic        busy;
    logic        done;
    logic [3:0]  glb_re;
    logic [3:0]  glb_we;
    logic [31:0] glb_r_addr;
    logic [31:0] glb_w_addr;
    logic [31:0] glb_w_data;
    logic [31:0] glb_r_data;

    opsum_ppu dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .num_pix    (num_pix),
        .num_ch     (num_ch),
        .shift      (shift),
        .relu_en    (relu_en),
        .opsum_base (opsum_base),
        .bias_base  (bias_base),
        .out_base   (out_base),
        .glb_re     (glb_re),
        .glb_r_addr (glb_r_addr),
        .glb_r_data (glb_r_data),
        .glb_we     (glb_we),
        .glb_w_addr (glb_w_addr),
        .glb_w_data (glb_w_data)
    );

    always #5 clk = ~clk;

    logic [31:0] rmem    [0:4095];
    logic [31:0] wl_addr [0:4095];
    logic [31:0] wl_data [0:4095];
    logic [3:0]  wl_mask [0:4095];
    int rcnt = 0;
    int wcnt = 0;
    int ovl  = 0;

    // GLB: registered 1-cycle read, byte-masked write captured in a log.
    always @(posedge clk) begin
        if (glb_re != 4'b0000) begin
            glb_r_data <= rmem[glb_r_addr[13:2]];
            rcnt       <= rcnt + 1;
        end
        if (glb_we != 4'b0000) begin
            wl_addr[wcnt[11:0]] <= glb_w_addr;
            wl_mask[wcnt[11:0]] <= glb_we;
            wl_data[wcnt[11:0]] <= glb_w_data & {{8{glb_we[3]}}, {8{glb_we[2]}},
                                                 {8{glb_we[1]}}, {8{glb_we[0]}}};
            wcnt <= wcnt + 1;
        end
        if (glb_re != 4'b0000 && glb_we != 4'b0000) begin
            ovl <= ovl + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    logic [31:0] bv [0:31];
    logic [31:0] pv [0:255];

    // Reference requantizer using plain integer arithmetic and floor division.
    function automatic logic [7:0] mq(input int p, input int b, input int sh, input bit rl);
        longint s, d, q;
        s = longint'(p) + longint'(b);
        if (rl && s < 0) s = 0;
        if (sh > 0) begin
            d = longint'(1) << sh;
            s = s + d / 2;
            q = s / d;
            if ((s % d) != 0 && s < 0) q = q - 1;
            s = q;
        end
        if (rl) begin
            if (s > 255) s = 255;
        end else begin
            if (s > 127) s = 127;
            if (s < -128) s = -128;
        end
        return s[7:0];
    endfunction

    function automatic int cyc_exp(input int np, input int nc);
        int n;
        n = np * nc;
        return 2 * nc + 2 * n + (n + 3) / 4 + 1;
    endfunction

    task automatic load(input int np, input int nc);
        for (int i = 0; i < nc; i++) rmem[BIAS_W + i] = bv[i];
        for (int k = 0; k < np * nc; k++) rmem[OPS_W + k] = pv[k];
    endtask

    task automatic randomize_data(input int np, input int nc);
        for (int i = 0; i < nc; i++)
            bv[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 600)) - 32'd300;
        for (int k = 0; k < np * nc; k++)
            pv[k] = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 8000)) - 32'd4000;
    endtask

    task automatic run(input int np, input int nc, input int sh, input bit rl,
                       input bit dup, output int cyc, output int nd);
        int lim;
        lim = cyc_exp(np, nc) + 30;
        @(negedge clk);
        num_pix = 16'(np);
        num_ch  = 6'(nc);
        shift   = 5'(sh);
        relu_en = rl;
        start   = 1'b1;
        cyc = 0;
        nd  = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = (dup && (cyc == 3 || cyc == 6)) ? 1'b1 : 1'b0;
            if (cyc == 1 && np * nc != 0) chk("busy_run", busy, 1);
            if (done) begin
                nd++;
                break;
            end
            if (cyc >= lim) begin
                chk("run_timeout", done, 1);
                break;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("busy_after", busy, 0);
    endtask

    task automatic check_out(input string tag, input int np, input int nc,
                             input int sh, input bit rl, input int w0, input int r0);
        int n, nw, idx;
        logic [7:0]  bytes [$];
        logic [3:0]  m;
        logic [31:0] d;
        n = np * nc;
        for (int k = 0; k < n; k++)
            bytes.push_back(mq(int'(pv[k]), int'(bv[k % nc]), sh, rl));
        nw = (n + 3) / 4;
        chk({tag, "_nrd"}, rcnt - r0, nc + n);
        chk({tag, "_nwr"}, wcnt - w0, nw);
        for (int j = 0; j < nw && j < wcnt - w0; j++) begin
            idx = (w0 + j) % 4096;
            m = '0;
            d = '0;
            for (int b = 0; b < 4; b++) begin
                if (4 * j + b < n) begin
                    m[b] = 1'b1;
                    d[8*b +: 8] = bytes[4*j+b];
                end
            end
            chk({tag, "_addr"}, wl_addr[idx], OUT_B + 32'(4 * j));
            chk({tag, "_mask"}, wl_mask[idx], m);
            chk({tag, "_data"}, wl_data[idx], d);
        end
    endtask

    typedef struct packed {
        logic [3:0][31:0] b;
        logic [3:0][31:0] p;
        logic [4:0]       sh;
        logic             rl;
        logic [31:0]      w;
    } vec_t;

    vec_t tbl [5];

    function automatic vec_t mkv(input int b0, input int b1, input int b2, input int b3,
                                 input int p0, input int p1, input int p2, input int p3,
                                 input int sh, input bit rl, input logic [31:0] w);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.sh = 5'(sh);
        v.rl = rl;
        v.w  = w;
        return v;
    endfunction

    initial begin
        int cyc, nd, w0, r0, np, nc, sh;
        bit rl;

        tbl[0] = mkv(10, -5, 0, 100, 90, 5, -7, 1000, 0, 1'b1, 32'hFF00_0064);
        tbl[1] = mkv(0, 0, 0, 0, 6, -6, -600, 600, 2, 1'b0, 32'h7F80_FF02);
        tbl[2] = mkv(0, 0, 0, 0, 15, 16, 4095, -100, 4, 1'b1, 32'h00FF_0101);
        tbl[3] = mkv(127, -128, 1, -1, 0, 0, 127, -128, 0, 1'b0, 32'h807F_807F);
        tbl[4] = mkv(32'h7FFF_FFFF, 32'h8000_0000, 0, 0,
                     32'h7FFF_FFFF, 32'h8000_0000, 100, -1, 31, 1'b0, 32'h0000_FE02);

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_re", glb_re, 0);
        chk("rst_we", glb_we, 0);
        chk("rst_raddr", glb_r_addr, 0);
        chk("rst_waddr", glb_w_addr, 0);
        chk("rst_wdata", glb_w_data, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 4; c++) begin
                bv[c] = tbl[i].b[c];
                pv[c] = tbl[i].p[c];
            end
            load(1, 4);
            w0 = wcnt;
            r0 = rcnt;
            run(1, 4, int'(tbl[i].sh), tbl[i].rl, 1'b0, cyc, nd);
            chk($sformatf("vec%0d_cycles", i), cyc, 18);
            chk($sformatf("vec%0d_ndone", i), nd, 1);
            chk($sformatf("vec%0d_nrd", i), rcnt - r0, 8);
            chk($sformatf("vec%0d_nwr", i), wcnt - w0, 1);
            chk($sformatf("vec%0d_addr", i), wl_addr[w0 % 4096], OUT_B);
            chk($sformatf("vec%0d_mask", i), wl_mask[w0 % 4096], 4'b1111);
            chk($sformatf("vec%0d_word", i), wl_data[w0 % 4096], tbl[i].w);
        end

        randomize_data(3, 2);
        load(3, 2);
        w0 = wcnt;
        r0 = rcnt;
        run(3, 2, 3, 1'b0, 1'b0, cyc, nd);
        chk("n6_cycles", cyc, 19);
        chk("n6_ndone", nd, 1);
        check_out("n6", 3, 2, 3, 1'b0, w0, r0);

        w0 = wcnt;
        r0 = rcnt;
        run(5, 0, 0, 1'b1, 1'b0, cyc, nd);
        chk("nc0_cycles", cyc, 1);
        chk("nc0_ndone", nd, 1);
        chk("nc0_acc", (rcnt - r0) + (wcnt - w0), 0);
        run(0, 3, 0, 1'b0, 1'b0, cyc, nd);
        chk("np0_cycles", cyc, 1);
        chk("np0_acc", (rcnt - r0) + (wcnt - w0), 0);

        randomize_data(4, 3);
        load(4, 3);
        w0 = wcnt;
        r0 = rcnt;
        run(4, 3, 5, 1'b1, 1'b1, cyc, nd);
        chk("dup_cycles", cyc, cyc_exp(4, 3));
        chk("dup_ndone", nd, 1);
        check_out("dup", 4, 3, 5, 1'b1, w0, r0);

        randomize_data(2, 4);
        load(2, 4);
        @(negedge clk);
        num_pix = 16'd2;
        num_ch  = 6'd4;
        shift   = 5'd1;
        relu_en = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_re", glb_re, 0);
        chk("mid_we", glb_we, 0);
        chk("mid_raddr", glb_r_addr, 0);
        chk("mid_waddr", glb_w_addr, 0);
        chk("mid_wdata", glb_w_data, 0);
        w0 = wcnt;
        r0 = rcnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_quiet", (rcnt - r0) + (wcnt - w0), 0);
        w0 = wcnt;
        r0 = rcnt;
        run(2, 4, 1, 1'b0, 1'b0, cyc, nd);
        chk("rerun_cycles", cyc, cyc_exp(2, 4));
        check_out("rerun", 2, 4, 1, 1'b0, w0, r0);

        for (int it = 0; it < 10; it++) begin
            np = $urandom_range(1, 6);
            nc = $urandom_range(1, 32);
            sh = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 31) : $urandom_range(0, 12);
            rl = 1'($urandom_range(0, 1));
            randomize_data(np, nc);
            load(np, nc);
            w0 = wcnt;
            r0 = rcnt;
            run(np, nc, sh, rl, 1'b0, cyc, nd);
            chk($sformatf("rnd%0d_cycles", it), cyc, cyc_exp(np, nc));
            chk($sformatf("rnd%0d_ndone", it), nd, 1);
            check_out($sformatf("rnd%0d", it), np, nc, sh, rl, w0, r0);
        end

        chk("no_overlap", ovl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
